balsa_operand_feeder: RTL and testbench

- Clocked operand source that sits directly upstream of the 8-bit Balsa adder.
- It serves that adder's two 4-phase pull channels, the i1/i2 operand inputs, from a FIFO of operand pairs.
- The FIFO is filled by a synchronous valid/ready producer.
- It bridges the clocked test and host environment into the self-timed datapath, with bundled data held stable for the whole handshake.

---
 rtl/balsa_operand_feeder.sv | 195 +++++++++++++++++++
 tb/tb_balsa_operand_feeder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/balsa_operand_feeder.sv
// ---------------------------------------------------------------------------
// balsa_operand_feeder
//
// Clocked operand source for the 8-bit Balsa adder. A synchronous
// valid/ready producer fills a FIFO of operand pairs {a, b}. The adder pulls
// operand A on the i1 channel and operand B on the i2 channel. Each channel
// uses a 4-phase handshake with bundled data. A pair is retired only after
// both channels have completed a full handshake on it.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   in_valid / in_ready producer handshake for the pair {in_a, in_b}
//   in_a, in_b          operands later served on i1 and i2
//   i1_0r / i1_0a       operand A pull request (asynchronous) / acknowledge
//   i1_0d               operand A data, valid while i1_0a is high
//   i2_0r / i2_0a       operand B pull request (asynchronous) / acknowledge
//   i2_0d               operand B data, valid while i2_0a is high
//   count               number of occupied FIFO entries
//
// Per-channel handshake sequence
//   IDLE --(rS & non-empty)--> LOAD --> ACK --(!rS)--> DONE --(pop)--> IDLE
// The data register loads on the edge that enters LOAD. The ack rises one
// cycle later, so the bundled data is set up a full cycle ahead of the ack.
// ---------------------------------------------------------------------------
module balsa_operand_feeder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       i1_0r,
    output logic                       i1_0a,
    output logic [WIDTH-1:0]           i1_0d,
    input  logic                       i2_0r,
    output logic                       i2_0a,
    output logic [WIDTH-1:0]           i2_0d,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } chan_state_t;

    // -----------------------------------------------------------------------
    // Shared FIFO bookkeeping
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

    // Per-channel views, indexed 0 = i1 (operand A), 1 = i2 (operand B)
    logic [1:0]            req_raw;
    logic [1:0]            req_sync;
    logic [1:0]            chan_done;
    logic [1:0]            chan_ack;
    logic [1:0][WIDTH-1:0] chan_data;
    logic [1:0][WIDTH-1:0] operand_in;

    assign req_raw       = {i2_0r, i1_0r};
    assign operand_in[0] = in_a;
    assign operand_in[1] = in_b;

    assign in_ready      = (count_reg != CNT_W'(DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign push          = in_valid & in_ready;
    // A pair retires only when both channels have finished their handshake.
    // Until then, a channel that finished first stays parked in DONE. This
    // stops it from pulling the same head pair twice.
    assign pop           = &chan_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel resources. Each channel has its own storage, request
    // synchronizer, handshake FSM and bundled-data register.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [WIDTH-1:0]       mem_reg [DEPTH];
        logic [SYNC_STAGES-1:0] sync_reg;
        chan_state_t            state_reg;
        chan_state_t            state_next;
        logic                   load_en;
        logic                   ack_reg;
        logic [WIDTH-1:0]       data_reg;

        // Operand storage. There is no reset: a location is read only after
        // it has been written by a push.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= operand_in[gi];
            end
        end

        // The request comes from the self-timed domain, so it goes through
        // a plain flip-flop chain. Only the last stage is used by the logic.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_reg <= '0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], req_raw[gi]};
            end
        end
        assign req_sync[gi] = sync_reg[SYNC_STAGES-1];

        always_comb begin
            state_next = state_reg;
            load_en    = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_sync[gi] && fifo_nonempty) begin
                        state_next = ST_LOAD;
                        load_en    = 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_next = ST_ACK;
                end
                ST_ACK: begin
                    if (!req_sync[gi]) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (pop) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                ack_reg   <= 1'b0;
                data_reg  <= '0;
            end else begin
                state_reg <= state_next;
                // The ack comes from its own flop, so it cannot glitch into
                // the self-timed adder.
                ack_reg   <= (state_next == ST_ACK);
                // Registered read of the head entry. This happens only on
                // IDLE->LOAD, so the data is held through ACK and DONE.
                if (load_en) begin
                    data_reg <= mem_reg[rd_ptr_reg];
                end
            end
        end

        assign chan_done[gi] = (state_reg == ST_DONE);
        assign chan_ack[gi]  = ack_reg;
        assign chan_data[gi] = data_reg;
    end

    assign i1_0a = chan_ack[0];
    assign i1_0d = chan_data[0];
    assign i2_0a = chan_ack[1];
    assign i2_0d = chan_data[1];
    assign count = count_reg;

endmodule

// File: tb/tb_balsa_operand_feeder.sv
// ---------------------------------------------------------------------------
// Testbench for balsa_operand_feeder.
//
// Reference model:
//   - Every accepted pair is appended to the queues qa / qb.
//   - ch_idx[c] is the index of the next pair that channel c must serve.
//   - Pairs retired = min(ch_idx), so occupancy = pushes - pairs retired.
// ---------------------------------------------------------------------------
module tb_balsa_operand_feeder;

    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          i1_0r;
    logic          i1_0a;
    logic [W-1:0]  i1_0d;
    logic          i2_0r;
    logic          i2_0a;
    logic [W-1:0]  i2_0d;
    logic [CW-1:0] count;

    balsa_operand_feeder #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .i1_0r    (i1_0r),
        .i1_0a    (i1_0a),
        .i1_0d    (i1_0d),
        .i2_0r    (i2_0r),
        .i2_0a    (i2_0a),
        .i2_0d    (i2_0d),
        .count    (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           ch_idx[2];

    function automatic int model_count();
        int pops;
        pops = (ch_idx[0] < ch_idx[1]) ? ch_idx[0] : ch_idx[1];
        return qa.size() - pops;
    endfunction

    function automatic logic get_ack(int c);
        return (c == 0) ? i1_0a : i2_0a;
    endfunction

    function automatic logic [W-1:0] get_data(int c);
        return (c == 0) ? i1_0d : i2_0d;
    endfunction

    task automatic set_req(int c, logic v);
        if (c == 0) i1_0r = v;
        else        i2_0r = v;
    endtask

    task automatic wait_ack(int c, logic lvl, int maxc, output int cyc);
        cyc = 0;
        while (get_ack(c) !== lvl && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Offer one pair for one cycle. The model predicts whether it is
    // accepted from its own occupancy.
    task automatic push_pair(logic [W-1:0] a, logic [W-1:0] b);
        logic exp_rdy;
        @(negedge clk);
        exp_rdy  = (model_count() < D);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL push_ready a=%0h b=%0h: in_ready=%0b expected %0b", a, b, in_ready, exp_rdy);
        end
        if (exp_rdy) begin
            qa.push_back(a);
            qb.push_back(b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full 4-phase handshake on channel c. When exp_lat > 0, the rise
    // latency is also checked.
    task automatic run_hs(int c, int exp_lat);
        int cyc;
        logic [W-1:0] exp_d;
        @(negedge clk);
        set_req(c, 1'b1);
        wait_ack(c, 1'b1, 80, cyc);
        checks++;
        if (get_ack(c) !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_rise ch=%0d: ack=%0b expected 1 within 80 cycles", c, get_ack(c));
        end else begin
            if (exp_lat > 0) begin
                checks++;
                if (cyc != exp_lat) begin
                    errors++;
                    $display("FAIL hs_rise_latency ch=%0d: %0d cycles expected %0d", c, cyc, exp_lat);
                end
            end
            checks++;
            if (ch_idx[c] >= qa.size()) begin
                errors++;
                $display("FAIL hs_unexpected_ack ch=%0d: ack=1 expected no pair available", c);
            end else begin
                exp_d = (c == 0) ? qa[ch_idx[c]] : qb[ch_idx[c]];
                if (get_data(c) !== exp_d) begin
                    errors++;
                    $display("FAIL hs_data ch=%0d pair=%0d: data=%0h expected %0h", c, ch_idx[c], get_data(c), exp_d);
                end
            end
        end
        set_req(c, 1'b0);
        wait_ack(c, 1'b0, 80, cyc);
        checks++;
        if (get_ack(c) !== 1'b0 || cyc != S + 1) begin
            errors++;
            $display("FAIL hs_fall ch=%0d: ack=%0b after %0d cycles expected 0 after %0d", c, get_ack(c), cyc, S + 1);
        end
        ch_idx[c]++;
        $display("hs ch=%0d pair=%0d data=%0h", c, ch_idx[c] - 1, get_data(c));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        i1_0r = 1'b0; i2_0r = 1'b0;
        ch_idx[0] = 0; ch_idx[1] = 0;
        repeat (3) @(negedge clk);
        checks++; if (count !== '0)     begin errors++; $display("FAIL reset_count: %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %0b expected 1", in_ready); end
        checks++; if (i1_0a !== 1'b0)   begin errors++; $display("FAIL reset_i1_0a: %0b expected 0", i1_0a); end
        checks++; if (i2_0a !== 1'b0)   begin errors++; $display("FAIL reset_i2_0a: %0b expected 0", i2_0a); end
        checks++; if (i1_0d !== '0)     begin errors++; $display("FAIL reset_i1_0d: %0h expected 0", i1_0d); end
        checks++; if (i2_0d !== '0)     begin errors++; $display("FAIL reset_i2_0d: %0h expected 0", i2_0d); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_first_pair();
        int cyc;
        push_pair(8'd3, 8'd5);
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL first_count: %0d expected %0d", count, model_count()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: %0b expected 1", in_ready); end
        checks++; if (i1_0a !== 1'b0 || i2_0a !== 1'b0) begin errors++; $display("FAIL first_idle_acks: %0b%0b expected 00", i1_0a, i2_0a); end
        i1_0r = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (i1_0d !== 8'd3 || i1_0a !== 1'b0) begin errors++; $display("FAIL first_setup cycle3: d=%0h a=%0b expected d=3 a=0", i1_0d, i1_0a); end
        @(negedge clk);
        checks++; if (i1_0a !== 1'b1 || i1_0d !== 8'd3) begin errors++; $display("FAIL first_ack cycle4: a=%0b d=%0h expected a=1 d=3", i1_0a, i1_0d); end
        i1_0r = 1'b0;
        wait_ack(0, 1'b0, 20, cyc);
        checks++; if (cyc != S + 1) begin errors++; $display("FAIL first_fall: %0d cycles expected %0d", cyc, S + 1); end
        ch_idx[0]++;
        run_hs(1, S + 2);
        repeat (2) @(negedge clk);
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL first_drain_count: %0d expected %0d", count, model_count()); end
        $display("first pair done count=%0d", count);
    endtask

    task automatic test_pairs();
        int cyc;
        push_pair(8'h10, 8'h20);
        push_pair(8'hFF, 8'h01);
        for (int k = 0; k < 2; k++) begin
            run_hs(0, S + 2);
            run_hs(1, S + 2);
            repeat (2) @(negedge clk);
            checks++;
            if (count !== CW'(model_count())) begin errors++; $display("FAIL pairs_count k=%0d: %0d expected %0d", k, count, model_count()); end
        end
        // A second i1 pull before i2 finishes must be held off.
        push_pair(8'($urandom), 8'($urandom));
        push_pair(8'($urandom), 8'($urandom));
        run_hs(0, S + 2);
        @(negedge clk);
        i1_0r = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (i1_0a !== 1'b0) begin errors++; $display("FAIL double_i1_held: ack=%0b expected 0", i1_0a); end
        run_hs(1, S + 2);
        wait_ack(0, 1'b1, 30, cyc);
        checks++;
        if (i1_0a !== 1'b1 || i1_0d !== qa[ch_idx[0]]) begin
            errors++;
            $display("FAIL double_i1_release: a=%0b d=%0h expected a=1 d=%0h", i1_0a, i1_0d, qa[ch_idx[0]]);
        end
        i1_0r = 1'b0;
        wait_ack(0, 1'b0, 20, cyc);
        ch_idx[0]++;
        run_hs(1, S + 2);
        repeat (2) @(negedge clk);
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL double_i1_count: %0d expected %0d", count, model_count()); end
        $display("pairs done count=%0d", count);
    endtask

    task automatic test_empty();
        int cyc;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        i1_0r = 1'b1; i2_0r = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (i1_0a !== 1'b0 || i2_0a !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL empty_hold: ack seen=1 expected 0"); end
        push_pair(8'd7, 8'd9);
        wait_ack(0, 1'b1, 20, cyc);
        checks++; if (cyc != 2 || i2_0a !== 1'b1) begin errors++; $display("FAIL empty_wake: %0d cycles i2_0a=%0b expected 2 cycles i2_0a=1", cyc, i2_0a); end
        checks++; if (i1_0d !== 8'd7 || i2_0d !== 8'd9) begin errors++; $display("FAIL empty_data: %0h %0h expected 7 9", i1_0d, i2_0d); end
        i1_0r = 1'b0; i2_0r = 1'b0;
        wait_ack(0, 1'b0, 20, cyc);
        wait_ack(1, 1'b0, 20, cyc);
        ch_idx[0]++; ch_idx[1]++;
        repeat (2) @(negedge clk);
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL empty_count: %0d expected %0d", count, model_count()); end
        $display("empty done count=%0d", count);
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) push_pair(8'($urandom), 8'($urandom));
        checks++; if (in_ready !== 1'b0 || count !== CW'(D)) begin errors++; $display("FAIL full_state: rdy=%0b count=%0d expected rdy=0 count=%0d", in_ready, count, D); end
        checks++; if (model_count() != D) begin errors++; $display("FAIL full_model: %0d expected %0d", model_count(), D); end
        run_hs(0, S + 2);
        run_hs(1, S + 2);
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1 || count !== CW'(D - 1)) begin errors++; $display("FAIL full_release: rdy=%0b count=%0d expected rdy=1 count=%0d", in_ready, count, D - 1); end
        for (int k = 0; k < D - 1; k++) begin
            fork
                run_hs(0, 0);
                run_hs(1, 0);
            join
        end
        repeat (2) @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL full_drain: %0d expected 0", count); end
        $display("full done count=%0d", count);
    endtask

    task automatic test_back_to_back();
        int n = 8;
        int pops_seen = 0;
        int base = ch_idx[0];
        bit mon_run = 1'b1;
        bit bad_step = 1'b0;
        fork
            begin
                fork
                    begin
                        int sent = 0;
                        while (sent < n) begin
                            @(negedge clk);
                            in_valid = 1'b1;
                            in_a = 8'($urandom);
                            in_b = 8'($urandom);
                            if (in_ready) begin
                                qa.push_back(in_a);
                                qb.push_back(in_b);
                                sent++;
                            end
                        end
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                    begin
                        for (int k = 0; k < n; k++) begin
                            fork
                                run_hs(0, 0);
                                run_hs(1, 0);
                            join
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                        end
                    end
                join
                repeat (3) @(negedge clk);
                mon_run = 1'b0;
            end
            begin
                int guard = 0;
                int prev;
                int delta;
                int fire;
                @(negedge clk); #2;
                while (mon_run && guard < 3000) begin
                    prev = int'(count);
                    fire = (in_valid && in_ready) ? 1 : 0;
                    @(negedge clk); #2;
                    delta = int'(count) - prev;
                    if ((fire - delta) < 0 || (fire - delta) > 1 || int'(count) > D) bad_step = 1'b1;
                    else pops_seen += fire - delta;
                    guard++;
                end
            end
        join
        checks++; if (bad_step) begin errors++; $display("FAIL b2b_count_step: inconsistent count step seen=1 expected 0"); end
        checks++; if (pops_seen != (ch_idx[0] - base)) begin errors++; $display("FAIL b2b_pops: %0d expected %0d", pops_seen, ch_idx[0] - base); end
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL b2b_final_count: %0d expected %0d", count, model_count()); end
        $display("back_to_back done pops=%0d count=%0d", pops_seen, count);
    endtask

    task automatic test_reset_mid();
        int cyc;
        push_pair(8'($urandom), 8'($urandom));
        @(negedge clk);
        i2_0r = 1'b1;
        wait_ack(1, 1'b1, 20, cyc);
        checks++; if (i2_0a !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ack: %0b expected 1", i2_0a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (i2_0a !== 1'b0 || count !== '0) begin errors++; $display("FAIL rstmid_async: ack=%0b count=%0d expected 0 0", i2_0a, count); end
        i2_0r = 1'b0;
        ch_idx[0] = qa.size(); ch_idx[1] = qa.size();
        @(negedge clk);
        rst_n = 1'b1;
        push_pair(8'($urandom), 8'($urandom));
        run_hs(0, S + 2);
        run_hs(1, S + 2);
        repeat (2) @(negedge clk);
        checks++; if (count !== CW'(model_count())) begin errors++; $display("FAIL rstmid_after: %0d expected %0d", count, model_count()); end
        $display("reset_mid done count=%0d", count);
    endtask

    initial begin
        test_reset();
        test_first_pair();
        test_pairs();
        test_empty();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

endmodule
